// File: rtl/dual_issue_scheduler_pkg.sv
// Shared types and constants for the dual-issue decode scheduler.
// Holds the FSM encodings, register constants and the register-match helper.
package dual_issue_scheduler_pkg;

  typedef enum logic [1:0] {
    S_PAIR    = 2'd0,
    S_SPLIT2  = 2'd1,
    S_LDSTALL = 2'd2
  } schedState_e;

  localparam logic [4:0] REG_ZERO   = 5'd0;
  localparam logic [4:0] REG_STATUS = 5'd30;
  localparam int MD_LATENCY_DEF     = 32;

  // r0 never creates a dependency
  function automatic logic regMatch(
    input logic [4:0] a,
    input logic [4:0] b
  );
    return (a != REG_ZERO) && (a == b);
  endfunction

endpackage

// File: rtl/dual_issue_scheduler_md_busy_counter.sv
// Busy counter for the shared mult/div unit.
// Loads the latency on start, counts down and saturates at zero.
module md_busy_counter #(
  parameter int MD_LATENCY = 32,
  parameter int CNT_W      = 6
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  output logic busy
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= CNT_W'(MD_LATENCY);
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/dual_issue_scheduler.sv
// Decode-stage issue controller for the 2-wide pipeline.
// Optional perf counters are built when SCHED_PERF_EN is defined.
module dual_issue_scheduler
  import dual_issue_scheduler_pkg::*;
#(
  parameter int MD_LATENCY = MD_LATENCY_DEF,
  parameter int CNT_W      = 6
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       flush,
  input  logic       D_valid_1,
  input  logic       D_valid_2,
  input  logic [4:0] D_rs_1,
  input  logic [4:0] D_rs_2,
  input  logic [4:0] D_rt_1,
  input  logic [4:0] D_rt_2,
  input  logic [4:0] D_rd_1,
  input  logic [4:0] D_rd_2,
  input  logic       D_regWrite_1,
  input  logic       D_regWrite_2,
  input  logic       D_isMD_1,
  input  logic       D_isMD_2,
  input  logic       D_isBr_1,
  input  logic [4:0] DX_rd_1,
  input  logic [4:0] DX_rd_2,
  input  logic       DX_memToReg_1,
  input  logic       DX_memToReg_2,
  output logic       issue_1,
  output logic       issue_2,
  output logic       stall_F,
  output logic       md_start,
  output logic       md_sel,
  output logic       md_busy
`ifdef SCHED_PERF_EN
  ,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_split
`endif
);

  schedState_e state;
  schedState_e stateNext;

  logic pend1, pend2;
  logic lu1, lu2;
  logic str1, str2;
  logic raw, waw, mustSplit;
  logic iss1, iss2;
  logic stallRaw;

  function automatic logic luHit(
    input logic       ld,
    input logic [4:0] dxRd,
    input logic [4:0] rs,
    input logic [4:0] rt
  );
    return ld & (regMatch(dxRd, rs) | regMatch(dxRd, rt));
  endfunction

  always_comb begin
    pend1 = (state == S_PAIR) & D_valid_1;
    pend2 = (state != S_LDSTALL) & D_valid_2;

    lu1 = pend1 &
          (luHit(DX_memToReg_1, DX_rd_1, D_rs_1, D_rt_1) |
           luHit(DX_memToReg_2, DX_rd_2, D_rs_1, D_rt_1));
    lu2 = pend2 &
          (luHit(DX_memToReg_1, DX_rd_1, D_rs_2, D_rt_2) |
           luHit(DX_memToReg_2, DX_rd_2, D_rs_2, D_rt_2));

    str1 = pend1 & D_isMD_1 & md_busy;
    str2 = pend2 & D_isMD_2 & md_busy;

    raw = D_regWrite_1 &
          (regMatch(D_rd_1, D_rs_2) | regMatch(D_rd_1, D_rt_2));
    waw = D_regWrite_1 & D_regWrite_2 & regMatch(D_rd_1, D_rd_2);
    mustSplit = raw | waw | D_isBr_1 | (D_isMD_1 & D_isMD_2);
  end

  always_comb begin
    iss1      = 1'b0;
    iss2      = 1'b0;
    stateNext = state;
    unique case (state)
      S_PAIR: begin
        if (lu1 | lu2) begin
          stateNext = S_LDSTALL;
        end else if (!str1) begin
          iss1 = pend1;
          if (pend2) begin
            if (str2 | (pend1 & mustSplit)) begin
              if (pend1) stateNext = S_SPLIT2;
            end else begin
              iss2 = 1'b1;
            end
          end
        end
      end
      S_SPLIT2: begin
        iss2 = pend2 & ~lu2 & ~str2;
        if (iss2 | ~pend2) stateNext = S_PAIR;
      end
      S_LDSTALL: stateNext = S_PAIR;
      default:   stateNext = S_PAIR;
    endcase
    // the squashed pair is not pending, so the front end is not held
    if (flush) begin
      iss1      = 1'b0;
      iss2      = 1'b0;
      stateNext = S_PAIR;
    end
  end

  always_comb begin
    if (state == S_LDSTALL) stallRaw = 1'b1;
    else stallRaw = (pend1 & ~iss1) | (pend2 & ~iss2);
  end

  assign issue_1  = ~reset & iss1;
  assign issue_2  = ~reset & iss2;
  assign stall_F  = ~reset & ~flush & stallRaw;
  assign md_start = ~reset & ((iss1 & D_isMD_1) | (iss2 & D_isMD_2));
  assign md_sel   = ~reset & iss2 & D_isMD_2 & ~(iss1 & D_isMD_1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_PAIR;
    else state <= stateNext;
  end

  md_busy_counter #(
    .MD_LATENCY(MD_LATENCY),
    .CNT_W     (CNT_W)
  ) u_cnt (
    .clock(clock),
    .reset(reset),
    .start(md_start),
    .busy (md_busy)
  );

`ifdef SCHED_PERF_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_stall <= '0;
      perf_split <= '0;
    end else begin
      if (stall_F & (D_valid_1 | D_valid_2))
        perf_stall <= perf_stall + 32'd1;
      if ((state == S_PAIR) & (stateNext == S_SPLIT2))
        perf_split <= perf_split + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Directed bench for dual_issue_scheduler.
// Covers pairing, splits, load-use, mult/div busy, flush and async reset.
module tb_dual_issue_scheduler;

  logic       clock = 1'b0;
  logic       reset;
  logic       flush;
  logic       D_valid_1, D_valid_2;
  logic [4:0] D_rs_1, D_rs_2, D_rt_1, D_rt_2, D_rd_1, D_rd_2;
  logic       D_regWrite_1, D_regWrite_2;
  logic       D_isMD_1, D_isMD_2, D_isBr_1;
  logic [4:0] DX_rd_1, DX_rd_2;
  logic       DX_memToReg_1, DX_memToReg_2;
  logic       issue_1, issue_2, stall_F;
  logic       md_start, md_sel, md_busy;
`ifdef SCHED_PERF_EN
  logic [31:0] perf_stall, perf_split;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  dual_issue_scheduler dut (
    .clock        (clock),
    .reset        (reset),
    .flush        (flush),
    .D_valid_1    (D_valid_1),
    .D_valid_2    (D_valid_2),
    .D_rs_1       (D_rs_1),
    .D_rs_2       (D_rs_2),
    .D_rt_1       (D_rt_1),
    .D_rt_2       (D_rt_2),
    .D_rd_1       (D_rd_1),
    .D_rd_2       (D_rd_2),
    .D_regWrite_1 (D_regWrite_1),
    .D_regWrite_2 (D_regWrite_2),
    .D_isMD_1     (D_isMD_1),
    .D_isMD_2     (D_isMD_2),
    .D_isBr_1     (D_isBr_1),
    .DX_rd_1      (DX_rd_1),
    .DX_rd_2      (DX_rd_2),
    .DX_memToReg_1(DX_memToReg_1),
    .DX_memToReg_2(DX_memToReg_2),
    .issue_1      (issue_1),
    .issue_2      (issue_2),
    .stall_F      (stall_F),
    .md_start     (md_start),
    .md_sel       (md_sel),
    .md_busy      (md_busy)
`ifdef SCHED_PERF_EN
    ,
    .perf_stall   (perf_stall),
    .perf_split   (perf_split)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    flush = 0;
    D_valid_1 = 0; D_valid_2 = 0;
    D_rs_1 = 0; D_rs_2 = 0; D_rt_1 = 0; D_rt_2 = 0;
    D_rd_1 = 0; D_rd_2 = 0;
    D_regWrite_1 = 0; D_regWrite_2 = 0;
    D_isMD_1 = 0; D_isMD_2 = 0; D_isBr_1 = 0;
    DX_rd_1 = 0; DX_rd_2 = 0;
    DX_memToReg_1 = 0; DX_memToReg_2 = 0;
  endtask

  task automatic pair(input logic [4:0] rd1, input logic [4:0] rs1,
                      input logic [4:0] rt1, input logic [4:0] rd2,
                      input logic [4:0] rs2, input logic [4:0] rt2);
    D_valid_1 = 1; D_valid_2 = 1;
    D_regWrite_1 = 1; D_regWrite_2 = 1;
    D_rd_1 = rd1; D_rs_1 = rs1; D_rt_1 = rt1;
    D_rd_2 = rd2; D_rs_2 = rs2; D_rt_2 = rt2;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic outs(input string tag, input logic i1, input logic i2,
                      input logic st);
    chk({tag, ".issue_1"}, 32'(issue_1), 32'(i1));
    chk({tag, ".issue_2"}, 32'(issue_2), 32'(i2));
    chk({tag, ".stall_F"}, 32'(stall_F), 32'(st));
  endtask

  initial begin
    idle();
    reset = 1;
    pair(5'd1, 5'd5, 5'd6, 5'd2, 5'd8, 5'd9);
    #3;
    outs("rst", 0, 0, 0);
    chk("rst.md_busy", 32'(md_busy), 0);
    step();
    reset = 0;

    // independent pair
    settle();
    outs("indep", 1, 1, 0);
    chk("indep.state", 32'(dut.state), 0);
    step();
    settle();
    chk("indep.state1", 32'(dut.state), 0);

    // intra-pair RAW splits
    idle();
    pair(5'd3, 5'd1, 5'd2, 5'd4, 5'd3, 5'd5);
    settle();
    outs("raw0", 1, 0, 1);
    step();
    settle();
    outs("raw1", 0, 1, 0);
    chk("raw1.state", 32'(dut.state), 1);
    step();

    // load-use bubble
    idle();
    pair(5'd1, 5'd7, 5'd6, 5'd2, 5'd8, 5'd9);
    DX_memToReg_2 = 1; DX_rd_2 = 7;
    settle();
    outs("lu0", 0, 0, 1);
    step();
    DX_memToReg_2 = 0; DX_rd_2 = 0;
    settle();
    outs("lu1", 0, 0, 1);
    chk("lu1.state", 32'(dut.state), 2);
    step();
    settle();
    outs("lu2", 1, 1, 0);
    step();

    // load into r0 is no hazard
    idle();
    pair(5'd1, 5'd0, 5'd6, 5'd2, 5'd8, 5'd9);
    DX_memToReg_1 = 1; DX_rd_1 = 0;
    settle();
    outs("luR0", 1, 1, 0);
    step();

    // mul in slot 1, div in slot 2
    idle();
    pair(5'd10, 5'd1, 5'd2, 5'd11, 5'd3, 5'd4);
    D_isMD_1 = 1; D_isMD_2 = 1;
    settle();
    outs("md0", 1, 0, 1);
    chk("md0.start", 32'(md_start), 1);
    chk("md0.sel", 32'(md_sel), 0);
    chk("md0.busy", 32'(md_busy), 0);
    step();
    settle();
    chk("md1.cnt", 32'(dut.u_cnt.cnt), 32);
    begin
      int bad = 0;
      for (int k = 1; k <= 32; k++) begin
        if (!md_busy || issue_2 || !stall_F) bad++;
        if (k < 32) step();
        if (k < 32) settle();
      end
      chk("md.busyWindow", 32'(bad), 0);
    end
    chk("md32.cnt", 32'(dut.u_cnt.cnt), 1);
    step();
    settle();
    chk("md33.busy", 32'(md_busy), 0);
    outs("md33", 0, 1, 0);
    chk("md33.start", 32'(md_start), 1);
    chk("md33.sel", 32'(md_sel), 1);
    step();
    idle();
    chk("mdRe.cnt", 32'(dut.u_cnt.cnt), 32);

    // branch splits, then flush in SPLIT2
    pair(5'd0, 5'd1, 5'd2, 5'd12, 5'd13, 5'd14);
    D_regWrite_1 = 0; D_isBr_1 = 1;
    settle();
    outs("br0", 1, 0, 1);
    step();
    flush = 1;
    settle();
    chk("fl.issue_2", 32'(issue_2), 0);
    chk("fl.start", 32'(md_start), 0);
    chk("fl.cnt", 32'(dut.u_cnt.cnt), 31);
    step();
    settle();
    chk("fl.state", 32'(dut.state), 0);
    chk("fl.cntKept", 32'(dut.u_cnt.cnt), 30);

    // flush beats load-use
    idle();
    flush = 1;
    pair(5'd1, 5'd7, 5'd6, 5'd2, 5'd8, 5'd9);
    DX_memToReg_1 = 1; DX_rd_1 = 7;
    settle();
    chk("flLu.issue_1", 32'(issue_1), 0);
    step();
    settle();
    chk("flLu.state", 32'(dut.state), 0);

    // WAW splits
    idle();
    pair(5'd5, 5'd1, 5'd2, 5'd5, 5'd3, 5'd4);
    settle();
    outs("waw0", 1, 0, 1);
    step();
    settle();
    outs("waw1", 0, 1, 0);
    step();

    // both invalid
    idle();
    settle();
    outs("inv", 0, 0, 0);
    step();

    // slot 2 MD blocked while busy, hold in SPLIT2 then reset
    pair(5'd3, 5'd1, 5'd2, 5'd6, 5'd3, 5'd4);
    D_isMD_2 = 1;
    settle();
    outs("str0", 1, 0, 1);
    for (int i = 0; i < 64 && dut.u_cnt.cnt != 10; i++) step();
    chk("str.cnt10", 32'(dut.u_cnt.cnt), 10);
    chk("str.state", 32'(dut.state), 1);
    #2;
    reset = 1;
    #1;
    outs("arst", 0, 0, 0);
    chk("arst.state", 32'(dut.state), 0);
    chk("arst.cnt", 32'(dut.u_cnt.cnt), 0);
    chk("arst.md_busy", 32'(md_busy), 0);
`ifdef SCHED_PERF_EN
    chk("arst.perf_stall", perf_stall, 0);
    chk("arst.perf_split", perf_split, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
